oam_dma_ctrl: RTL and testbench

OAM_DMA_CTRL -- requirements
Module: oam_dma_ctrl

---
 rtl/oam_dma_ctrl_pkg.sv | 18 +
 rtl/oam_dma_ctrl.sv | 101 ++++++++++
 tb/tb_oam_dma_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/oam_dma_ctrl_pkg.sv
// Shared widths, default bus addresses and state encoding for the OAM DMA controller.
package oam_dma_ctrl_pkg;

  localparam int ADDR_WIDTH = 16;
  localparam int REG_WIDTH  = 8;

  localparam logic [ADDR_WIDTH-1:0] DMA_REG_ADDR_DEF  = 16'h4014;
  localparam logic [ADDR_WIDTH-1:0] OAM_DATA_ADDR_DEF = 16'h2004;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HALT  = 3'd1,
    ST_ALIGN = 3'd2,
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4
  } dma_state_t;

endpackage

// File: rtl/oam_dma_ctrl.sv
// Sprite DMA engine: halts the CPU, then copies one 256-byte page into the
// OAM data port as alternating read/write bus cycles.
module oam_dma_ctrl
  import oam_dma_ctrl_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] DMA_REG_ADDR  = DMA_REG_ADDR_DEF,
  parameter logic [ADDR_WIDTH-1:0] OAM_DATA_ADDR = OAM_DATA_ADDR_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [REG_WIDTH-1:0]  cpu_dout,
  input  logic                  cpu_rw_n,
  input  logic [REG_WIDTH-1:0]  mem_rdata,
  output logic                  cpu_rdy,
  output logic                  bus_grant,
  output logic [ADDR_WIDTH-1:0] dma_addr,
  output logic [REG_WIDTH-1:0]  dma_data,
  output logic                  dma_rw_n,
  output logic                  dma_done
);

  dma_state_t           state_reg, state_next;
  logic [REG_WIDTH-1:0] page_reg, page_next;
  logic [REG_WIDTH-1:0] idx_reg, idx_next;
  logic [REG_WIDTH-1:0] data_buf_reg, data_buf_next;
  logic                 cycle_odd_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ST_IDLE;
      page_reg      <= '0;
      idx_reg       <= '0;
      data_buf_reg  <= '0;
      cycle_odd_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      page_reg      <= page_next;
      idx_reg       <= idx_next;
      data_buf_reg  <= data_buf_next;
      cycle_odd_reg <= ~cycle_odd_reg;
    end
  end

  // cpu_* inputs only steer next-state; every output decodes registered state.
  always_comb begin
    state_next    = state_reg;
    page_next     = page_reg;
    idx_next      = idx_reg;
    data_buf_next = data_buf_reg;
    cpu_rdy       = 1'b0;
    bus_grant     = 1'b0;
    dma_addr      = '0;
    dma_data      = '0;
    dma_rw_n      = 1'b1;
    dma_done      = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        cpu_rdy = 1'b1;
        if (!cpu_rw_n && (cpu_addr == DMA_REG_ADDR)) begin
          page_next  = cpu_dout;
          idx_next   = '0;
          state_next = ST_HALT;
        end
      end
      ST_HALT: begin
        // RDY cannot stall a write cycle, so wait for the CPU to reach a read.
        if (cpu_rw_n) begin
          state_next = cycle_odd_reg ? ST_ALIGN : ST_READ;
        end
      end
      ST_ALIGN: begin
        state_next = ST_READ;
      end
      ST_READ: begin
        bus_grant     = 1'b1;
        dma_addr      = {page_reg, idx_reg};
        data_buf_next = mem_rdata;
        state_next    = ST_WRITE;
      end
      ST_WRITE: begin
        bus_grant = 1'b1;
        dma_rw_n  = 1'b0;
        dma_addr  = OAM_DATA_ADDR;
        dma_data  = data_buf_reg;
        idx_next  = idx_reg + 8'd1;
        if (idx_reg == 8'hFF) begin
          dma_done   = 1'b1;
          state_next = ST_IDLE;
        end else begin
          state_next = ST_READ;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Randomised directed bench for oam_dma_ctrl against a transaction-level model.
module tb_oam_dma_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_rw_n;
  logic [7:0]  mem_rdata;
  logic        cpu_rdy;
  logic        bus_grant;
  logic [15:0] dma_addr;
  logic [7:0]  dma_data;
  logic        dma_rw_n;
  logic        dma_done;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem [0:65535];
  logic [31:0] cyc;

  typedef struct {
    logic        rw_n;
    logic [15:0] addr;
    logic [7:0]  data;
  } tx_t;

  always #5 clk = ~clk;

  assign mem_rdata = mem[dma_addr];

  // Clock edges since reset release; its LSB is the expected parity of the current cycle.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 32'd0;
    else          cyc <= cyc + 32'd1;
  end

  oam_dma_ctrl dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cpu_addr  (cpu_addr),
    .cpu_dout  (cpu_dout),
    .cpu_rw_n  (cpu_rw_n),
    .mem_rdata (mem_rdata),
    .cpu_rdy   (cpu_rdy),
    .bus_grant (bus_grant),
    .dma_addr  (dma_addr),
    .dma_data  (dma_data),
    .dma_rw_n  (dma_rw_n),
    .dma_done  (dma_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet_outputs(input string tag);
    chk({tag, "_rdy"},   32'(cpu_rdy),   32'd1);
    chk({tag, "_grant"}, 32'(bus_grant), 32'd0);
    chk({tag, "_rwn"},   32'(dma_rw_n),  32'd1);
    chk({tag, "_addr"},  32'(dma_addr),  32'd0);
    chk({tag, "_data"},  32'(dma_data),  32'd0);
    chk({tag, "_done"},  32'(dma_done),  32'd0);
  endtask

  // One transfer: trigger, hold the CPU in write cycles for 'hold' cycles, then
  // record every bus cycle until cpu_rdy returns. abort_idx >= 0 resets mid-way.
  task automatic run_xfer(input logic [7:0] page, input int hold, input bit want_odd,
                          input bit garbage, input int abort_idx);
    tx_t got[$];
    int  k = 0, low = 0, grant_low = 0, done_cnt = 0, done_bad = 0, idle_bad = 0;
    int  seq_bad = 0, first_bad = -1;
    bit  odd_exp = 1'b0, finished = 1'b0, aborted = 1'b0;
    logic [15:0] ra;

    for (int i = 0; i < 256; i++) begin
      ra = {page, 8'(i)};
      mem[ra] = 8'($urandom);
    end

    @(negedge clk);
    if ((cyc[0] ^ 1'b1 ^ 1'(hold)) != want_odd) @(negedge clk);
    chk("pre_trigger_rdy", 32'(cpu_rdy), 32'd1);
    cpu_addr = 16'h4014;
    cpu_dout = page;
    cpu_rw_n = 1'b0;

    while (k < 1000) begin
      @(negedge clk);
      if (cpu_rdy === 1'b1) begin
        finished = 1'b1;
        break;
      end
      low++;
      if (!bus_grant) begin
        grant_low++;
        if (dma_rw_n !== 1'b1 || dma_addr !== 16'h0 || dma_data !== 8'h0 || dma_done !== 1'b0)
          idle_bad++;
      end else begin
        got.push_back('{dma_rw_n, dma_addr, dma_data});
      end
      if (dma_done) begin
        done_cnt++;
        if (!(bus_grant && !dma_rw_n && got.size() == 512)) done_bad++;
      end
      if (abort_idx >= 0 && bus_grant && dma_rw_n && dma_addr == {page, 8'(abort_idx)}) begin
        aborted = 1'b1;
        break;
      end
      if (k < hold) begin
        cpu_rw_n = 1'b0;
        cpu_addr = ($urandom_range(0, 1) == 0) ? 16'h4014 : 16'($urandom);
        cpu_dout = 8'($urandom);
      end else if (k == hold) begin
        cpu_rw_n = 1'b1;
        cpu_addr = 16'($urandom);
        odd_exp  = cyc[0];
      end else if (garbage && bus_grant && $urandom_range(0, 3) == 0) begin
        cpu_rw_n = 1'b0;
        cpu_addr = 16'h4014;
        cpu_dout = 8'($urandom);
      end else begin
        cpu_rw_n = 1'b1;
        cpu_addr = 16'($urandom);
      end
      k++;
    end
    cpu_rw_n = 1'b1;
    cpu_addr = 16'h0000;

    if (aborted) begin
      reset_n = 1'b0;
      #1;
      check_quiet_outputs("abort");
      chk("abort_prefix_len", 32'(got.size()), 32'(abort_idx * 2 + 1));
      @(negedge clk);
      reset_n = 1'b1;
      $display("xfer page=%02h hold=%0d aborted at idx=%02h", page, hold, abort_idx);
      return;
    end

    chk("xfer_finished", 32'(finished), 32'd1);
    chk("post_grant", 32'(bus_grant), 32'd0);
    chk("post_done", 32'(dma_done), 32'd0);
    chk("rdy_low_cycles", 32'(low), 32'(hold + 1 + int'(odd_exp) + 512));
    chk("halt_no_grant_cycles", 32'(grant_low), 32'(hold + 1 + int'(odd_exp)));
    chk("idle_outputs_clean", 32'(idle_bad), 32'd0);
    chk("done_pulses", 32'(done_cnt), 32'd1);
    chk("done_on_last_write", 32'(done_bad), 32'd0);
    chk("bus_cycles", 32'(got.size()), 32'd512);
    if (got.size() == 512) begin
      for (int i = 0; i < 256; i++) begin
        ra = {page, 8'(i)};
        if (got[2*i].rw_n !== 1'b1 || got[2*i].addr !== ra ||
            got[2*i+1].rw_n !== 1'b0 || got[2*i+1].addr !== 16'h2004 ||
            got[2*i+1].data !== mem[ra]) begin
          seq_bad++;
          if (first_bad < 0) first_bad = i;
        end
      end
    end
    chk("pair_sequence_bad", 32'(seq_bad), 32'd0);
    $display("xfer page=%02h hold=%0d odd=%0d rdy_low=%0d first_bad=%0d",
             page, hold, odd_exp, low, first_bad);
  endtask

  initial begin
    int bad;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    reset_n  = 1'b0;
    cpu_addr = 16'h0000;
    cpu_dout = 8'h00;
    cpu_rw_n = 1'b1;
    repeat (3) @(negedge clk);
    check_quiet_outputs("reset");
    reset_n = 1'b1;

    // Near-miss accesses must never start a transfer.
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (cpu_rdy !== 1'b1 || bus_grant !== 1'b0) bad++;
      cpu_dout = 8'($urandom);
      if (i % 2 == 0) begin
        cpu_addr = 16'h4015;
        cpu_rw_n = 1'b0;
      end else begin
        cpu_addr = 16'h4014;
        cpu_rw_n = 1'b1;
      end
    end
    @(negedge clk);
    if (cpu_rdy !== 1'b1 || bus_grant !== 1'b0) bad++;
    cpu_rw_n = 1'b1;
    chk("no_trigger_bad_cycles", 32'(bad), 32'd0);
    $display("no-trigger accesses: bad cycles=%0d", bad);

    run_xfer(8'h02, 0, 1'b0, 1'b0, -1);
    run_xfer(8'h02, 0, 1'b1, 1'b0, -1);
    run_xfer(8'($urandom), 2, 1'($urandom), 1'b1, -1);
    run_xfer(8'($urandom), $urandom_range(1, 4), 1'($urandom), 1'b1, -1);
    run_xfer(8'($urandom_range(4, 255)), 0, 1'($urandom), 1'b0, 8'h40);
    run_xfer(8'h03, 0, 1'($urandom), 1'b1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
